pc_gen: RTL

Parametrised program-counter generator for the fetch stage. It holds the current fetch address and advances it under a valid/ready handshake with instruction memory. It applies redirects from execute (jump, taken branch) and from the CSR unit (trap entry, mret) with a fixed priority. Optionally, it detects misaligned control-transfer targets and parks in a fault state until the trap is taken.

---
 rtl/pc_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Holds the current fetch address, advances it under a valid/ready handshake
// with instruction memory, and applies redirects with fixed priority:
// trap > mret > jump > taken branch > sequential > hold.
// Optional feature macro: PC_MISALIGN_CHK_EN. When defined, misaligned jump or
// branch targets are not loaded; the block parks in FAULT until a trap arrives.
// When undefined, target low bits are cleared and the target is always loaded.
module pc_gen #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = 32'h0000_0000,
  parameter int                    INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ctrl_trans_instr_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  input  logic                  branch_tkn_i,
  input  logic [ADDR_WIDTH-1:0] tgt_addr_i,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  input  logic                  mret_i,
  input  logic [ADDR_WIDTH-1:0] mepc_i,
  input  logic                  stall_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] misalign_addr_o
);

  localparam logic [1:0] CTRL_JUMP   = 2'd1;
  localparam logic [1:0] CTRL_BRANCH = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK   = INCR - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~LOW_MASK;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] misalign_addr_q, misalign_addr_d;

  logic                  take_jump;
  logic                  take_branch;
  logic [ADDR_WIDTH-1:0] target;

  // Control-transfer decode: which redirect from execute is requested and its target.
  always_comb begin
    take_jump   = 1'b0;
    take_branch = 1'b0;
    target      = '0;
    if (ctrl_trans_instr_i == CTRL_JUMP) begin
      take_jump = 1'b1;
      target    = tgt_addr_i;
    end else if (ctrl_trans_instr_i == CTRL_BRANCH && branch_tkn_i) begin
      take_branch = 1'b1;
      target      = pc_q + offset_i;
    end
  end

  // Next-state and next-pc selection for the BOOT/RUN/FAULT machine.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;
    fetch_valid_o   = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (trap_i) begin
          pc_d = trap_vec_i & ALIGN_MASK;
        end else if (mret_i) begin
          pc_d = mepc_i & ALIGN_MASK;
        end
      end

      RUN: begin
        fetch_valid_o = 1'b1;
        if (trap_i) begin
          pc_d = trap_vec_i & ALIGN_MASK;
        end else if (mret_i) begin
          pc_d = mepc_i & ALIGN_MASK;
        end else if (take_jump || take_branch) begin
`ifdef PC_MISALIGN_CHK_EN
          if ((target & LOW_MASK) != '0) begin
            state_d         = FAULT;
            misalign_d      = 1'b1;
            misalign_addr_d = target;
          end else begin
            pc_d = target;
          end
`else
          pc_d = target & ALIGN_MASK;
`endif
        end else if (fetch_ready_i && !stall_i) begin
          pc_d = pc_q + INCR;
        end
      end

      FAULT: begin
        if (trap_i) begin
          state_d    = RUN;
          pc_d       = trap_vec_i & ALIGN_MASK;
          misalign_d = 1'b0;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, pc and fault registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_ADDR;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus_o       = pc_q + INCR;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule
